// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, state type and helpers for the calculator datapath
package calc_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_NINE = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_t;

    // 10**n, used to derive the overflow limit for a given digit count
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble corrector (adds 3 when the digit is 5 or more)
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] nibble,
    output logic [BCD_W-1:0] corrected
);

    // A digit of 5..9 would exceed 9 after the next doubling, so pre-bias it by 3
    assign corrected = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter, one bit per clock (optional BIN2BCD_BLANK_EN)
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int BIN_W  = 11,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int                BCD_TOT  = BCD_W * DIGITS;
    localparam int                CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BIN_W - 1);
    localparam logic [31:0]       LIMIT    = 32'(pow10(DIGITS));

    b2b_state_t              state;
    b2b_state_t              state_next;
    logic [1:0]              rst_pipe;
    logic                    rst_n;
    logic [BIN_W-1:0]        bin_sr;
    logic [BCD_TOT-1:0]      bcd_sr;
    logic [BCD_TOT-1:0]      bcd_adj;
    logic [BCD_TOT:0]        bcd_wide;
    logic [BCD_TOT-1:0]      bcd_result;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    ovf_cap;

    // Reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .nibble    (bcd_sr[g*BCD_W +: BCD_W]),
                .corrected (bcd_adj[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Corrected digits shift left with the next binary MSB entering digit 0; the bit
    // leaving the top digit means the value does not fit and is folded into overflow
    assign bcd_wide   = {bcd_adj, bin_sr[BIN_W-1]};
    assign bcd_result = (ovf_cap | bcd_wide[BCD_TOT]) ? {DIGITS{BCD_NINE}} : bcd_wide[BCD_TOT-1:0];

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              upper_zero;

    // A digit is blank when it and every higher digit are zero; digit 0 always shows
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero & (bcd_result[i*BCD_W +: BCD_W] == 4'h0);
            blank_next[i] = upper_zero;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; start is only honoured in IDLE
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (bit_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture on start, shift while converting, publish results only on the final shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr   <= '0;
            bcd_sr   <= '0;
            bit_cnt  <= '0;
            ovf_cap  <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        bcd_sr  <= '0;
                        bit_cnt <= LAST_BIT;
                        ovf_cap <= (32'(bin_in) >= LIMIT);
                    end
                end
                SHIFT: begin
                    bin_sr  <= bin_sr << 1;
                    bcd_sr  <= bcd_wide[BCD_TOT-1:0];
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    ovf_cap <= ovf_cap | bcd_wide[BCD_TOT];
                    if (bit_cnt == '0) begin
                        bcd_out  <= bcd_result;
                        overflow <= ovf_cap | bcd_wide[BCD_TOT];
`ifdef BIN2BCD_BLANK_EN
                        blank    <= blank_next;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (4-digit and 3-digit builds)
module tb_bin2bcd_seq;

    typedef struct {
        logic [10:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blk;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start3;
    logic [10:0] bin_in;
    logic [10:0] bin3;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd;
    logic        busy3;
    logic        done3;
    logic        ovf3;
    logic [11:0] bcd3;
`ifdef BIN2BCD_BLANK_EN
    logic [3:0]  blank;
    logic [2:0]  blank3;
`endif

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [15:0] o0_bcd [256];
    logic        o0_ovf [256];
    logic [3:0]  o0_blk [256];
    int          o0_cyc [256];
    int          o0_wr = 0;
    logic [15:0] o1_bcd [256];
    logic        o1_ovf [256];
    logic [3:0]  o1_blk [256];
    int          o1_cyc [256];
    int          o1_wr = 0;
    int          o0_rd = 0;
    int          o1_rd = 0;

    exp_t exp_q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(11), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd),
        .overflow (ovf)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank    (blank)
`endif
    );

    bin2bcd_seq #(.BIN_W(11), .DIGITS(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .start    (start3),
        .bin_in   (bin3),
        .busy     (busy3),
        .done     (done3),
        .bcd_out  (bcd3),
        .overflow (ovf3)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank    (blank3)
`endif
    );

    always @(negedge clk) begin
        if (done && o0_wr < 256) begin
            o0_bcd[o0_wr] <= bcd;
            o0_ovf[o0_wr] <= ovf;
`ifdef BIN2BCD_BLANK_EN
            o0_blk[o0_wr] <= blank;
`else
            o0_blk[o0_wr] <= 4'h0;
`endif
            o0_cyc[o0_wr] <= cyc;
            o0_wr         <= o0_wr + 1;
        end
    end

    always @(negedge clk) begin
        if (done3 && o1_wr < 256) begin
            o1_bcd[o1_wr] <= {4'h0, bcd3};
            o1_ovf[o1_wr] <= ovf3;
`ifdef BIN2BCD_BLANK_EN
            o1_blk[o1_wr] <= {1'b0, blank3};
`else
            o1_blk[o1_wr] <= 4'h0;
`endif
            o1_cyc[o1_wr] <= cyc;
            o1_wr         <= o1_wr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] exp_blk(input int n, input int digits);
        logic [3:0] r;
        int         p;
        r = '0;
        p = 10;
        for (int i = 1; i < digits; i++) begin
            r[i] = (n < p);
            p    = p * 10;
        end
        return r;
    endfunction

    task automatic push(input int which, input int val, input logic [15:0] eb, input logic eo, input int c);
        exp_t e;
        e.bcd = eb;
        e.ovf = eo;
        e.blk = exp_blk(eo ? ((which != 0) ? 999 : 9999) : val, (which != 0) ? 3 : 4);
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int which);
        int   need;
        int   have;
        int   waited;
        int   rd;
        exp_t e;
        need   = exp_q.size();
        waited = 0;
        rd     = (which != 0) ? o1_rd : o0_rd;
        while ((((which != 0) ? o1_wr : o0_wr) - rd) < need && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        repeat (16) @(posedge clk);
        have = ((which != 0) ? o1_wr : o0_wr) - rd;
        chk("done_count", 32'(have), 32'(need));
        for (int k = 0; k < need && k < have; k++) begin
            e = exp_q[k];
            if (which != 0) begin
                chk("bcd3", {16'h0, o1_bcd[rd+k]}, {16'h0, e.bcd});
                chk("ovf3", {31'h0, o1_ovf[rd+k]}, {31'h0, e.ovf});
                chk("latency3", 32'(o1_cyc[rd+k]), 32'(e.cyc));
`ifdef BIN2BCD_BLANK_EN
                chk("blank3", {28'h0, o1_blk[rd+k]}, {28'h0, e.blk});
`endif
            end else begin
                chk("bcd", {16'h0, o0_bcd[rd+k]}, {16'h0, e.bcd});
                chk("ovf", {31'h0, o0_ovf[rd+k]}, {31'h0, e.ovf});
                chk("latency", 32'(o0_cyc[rd+k]), 32'(e.cyc));
`ifdef BIN2BCD_BLANK_EN
                chk("blank", {28'h0, o0_blk[rd+k]}, {28'h0, e.blk});
`endif
            end
        end
        exp_q.delete();
        if (which != 0) o1_rd = o1_wr;
        else            o0_rd = o0_wr;
    endtask

    task automatic conv(input int which, input int val, input logic [15:0] eb, input logic eo);
        @(negedge clk);
        if (which != 0) begin
            start3 = 1'b1;
            bin3   = 11'(val);
        end else begin
            start  = 1'b1;
            bin_in = 11'(val);
        end
        push(which, val, eb, eo, cyc + 12);
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
        bin_in = 11'($urandom_range(0, 2047));
        bin3   = 11'($urandom_range(0, 2047));
        chk((which != 0) ? "busy3_after_start" : "busy_after_start",
            {31'h0, (which != 0) ? busy3 : busy}, 32'h1);
        drain(which);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{11'd1998, 16'h1998, 1'b0};
        vecs[1]  = '{11'd0,    16'h0000, 1'b0};
        vecs[2]  = '{11'd7,    16'h0007, 1'b0};
        vecs[3]  = '{11'd2047, 16'h2047, 1'b0};
        vecs[4]  = '{11'd456,  16'h0456, 1'b0};
        vecs[5]  = '{11'd9,    16'h0009, 1'b0};
        vecs[6]  = '{11'd10,   16'h0010, 1'b0};
        vecs[7]  = '{11'd99,   16'h0099, 1'b0};
        vecs[8]  = '{11'd100,  16'h0100, 1'b0};
        vecs[9]  = '{11'd1000, 16'h1000, 1'b0};
        vecs[10] = '{11'd1234, 16'h1234, 1'b0};
        vecs[11] = '{11'd5,    16'h0005, 1'b0};
        vecs[12] = '{11'd1024, 16'h1024, 1'b0};

        rst    = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        bin_in = '0;
        bin3   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_bcd", {16'h0, bcd}, 32'h0);
        chk("reset_ovf", {31'h0, ovf}, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            conv(0, int'(vecs[i].bin), vecs[i].bcd, vecs[i].ovf);
        end

        // start held high across two conversions; second accepted right after DONE
        @(negedge clk);
        start  = 1'b1;
        bin_in = 11'd7;
        push(0, 7, 16'h0007, 1'b0, cyc + 12);
        push(0, 2047, 16'h2047, 1'b0, cyc + 25);
        @(negedge clk);
        bin_in = 11'd2047;
        repeat (13) @(negedge clk);
        start = 1'b0;
        drain(0);

        // start during a conversion is dropped and the old result stays visible
        @(negedge clk);
        start  = 1'b1;
        bin_in = 11'd1998;
        push(0, 1998, 16'h1998, 1'b0, cyc + 12);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_mid_conversion", {16'h0, bcd}, 32'h2047);
        start  = 1'b1;
        bin_in = 11'd5;
        @(negedge clk);
        start = 1'b0;
        drain(0);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 11'd1998;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_bcd", {16'h0, bcd}, 32'h0);
        chk("abort_ovf", {31'h0, ovf}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        drain(0);
        conv(0, 456, 16'h0456, 1'b0);

        // three-digit build: saturation at the overflow boundary
        conv(1, 1000, 16'h0999, 1'b1);
        conv(1, 999,  16'h0999, 1'b0);
        conv(1, 2047, 16'h0999, 1'b1);
        conv(1, 5,    16'h0005, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
